hsyncgen_prog: RTL and testbench
================================

Name: hsyncgen_prog

Overview:
Parametrised successor to the fixed-mode horizontal sync generator in the video timing path. Provides a horizontal pixel-group counter of configurable width with runtime-programmable line length, hsync edges and display-enable edges. Emits a one-cycle line-end strobe (vertclk) to drive the vertical generator. All timing inputs are shadowed per line so mode switches never produce a truncated or glitched line.

Parameters:
HW, 7, counter width in bits (line length up to 2^HW)
DEF_LEN, 128, line length loaded into the shadow register on reset
DEF_HS_START, 101, hsync assert count after reset
DEF_HS_END, 111, hsync deassert count after reset
DEF_DE_START, 0, display-enable assert count after reset
DEF_DE_END, 80, display-enable deassert count after reset

Ports:
m2clock  in  1  clock
res  in  1  asynchronous active-high reset
cken  in  1  count enable; when low, all state holds
line_len  in  HW  counts per line; 0 means 2^HW
hs_start  in  HW  count at which hsync asserts
hs_end  in  HW  count at which hsync deasserts
de_start  in  HW  count at which display enable asserts
de_end  in  HW  count at which display enable deasserts
hsc  out  HW  current horizontal count
iihsync  out  1  horizontal sync, active low, registered
hde  out  1  horizontal display enable, active high, registered
vertclk  out  1  one-cycle line-end strobe, registered
halfclk  out  1  mid-line strobe (see Optional Feature)

Behaviour:
- Reset (async, res=1): hsc=0; iihsync=1; hde=0; vertclk=0; halfclk=0; shadows = DEF_* parameters.
- All state advances only on a rising m2clock edge with cken=1. With cken=0 every register holds, including strobes (a strobe high when cken falls stays high until the next enabled edge).
- Shadows: len_q, hs_start_q, hs_end_q, de_start_q and de_end_q sample their inputs on the enabled edge where hsc == len_q-1 (terminal count). New values apply from hsc=0 of the next line. Inputs changing mid-line have no effect on the current line.
- Counter: hsc increments by 1 per enabled edge. At terminal count (len_q-1, with len_q=0 meaning 2^HW) it wraps to 0 on the next enabled edge.
- len_q == 1: hsc is constantly 0, every enabled edge is terminal, and vertclk stays high continuously.
- vertclk: registered; 1 for exactly the enabled cycle following the edge where hsc was terminal, i.e. high while hsc==0.
- iihsync:
  - Cleared on the enabled edge where hsc == hs_start_q, so it is low from hsc == hs_start_q+1.
  - Set on the enabled edge where hsc == hs_end_q.
  - If hs_start_q == hs_end_q, clear wins: iihsync goes low and stays low.
  - A start or end value >= len_q never matches, so the level is held.
  - The level carries across line boundaries: a pulse may span the wrap.
- hde: identical rules, using de_start_q/de_end_q; set (to 1) wins on equality.
- Reset asserted mid-line aborts the line immediately. After release the counter restarts at 0 with DEF_* timing; no partial-line strobe is emitted.
- Arithmetic is modulo 2^HW. No output is combinational from the inputs.

Optional Feature:
Macro HSYNCGEN_HALFLINE_EN.
- Defined: halfclk is registered and high for one enabled cycle following the edge where hsc == (len_q>>1)-1, i.e. high while hsc == len_q>>1. Provides the interlace half-line reference. For len_q==0 the half point is 2^(HW-1). For len_q==1 the half point is 0.
- Not defined: halfclk is tied to 0 and no half-line comparator is built.

Test Plan:
- Reset release with defaults, cken=1 -> hsc runs 0..127 and wraps. vertclk is high only while hsc==0, period 128 cycles. iihsync is low for hsc 102..111 and high at 112. hde is high for hsc 1..80.
- line_len changed 128->100 at hsc=40 -> current line still ends at 127. The next line wraps at 99. vertclk period becomes 100 from that point.
- hs_start=hs_end=50 -> iihsync goes low at hsc=51 and stays low across subsequent lines.
- hs_start=90, hs_end=10, line_len=100 -> iihsync is low for hsc 91..99 and 0..10, high from hsc=11. No glitch at the wrap.
- cken toggled 1/0 alternately -> hsc advances every second cycle. Each strobe stays high for 2 clocks. Edge counts are unchanged.
- res pulsed at hsc=70 while iihsync=0 -> all outputs immediately take reset values. The next line is a full 128 counts. With HSYNCGEN_HALFLINE_EN defined, halfclk is high while hsc==64 and for line_len=100 while hsc==50.

Source files
------------

// File: rtl/hsyncgen_prog.sv
// hsyncgen_prog: horizontal sync generator whose line length and sync/enable edges are reloaded once per line.
// Define HSYNCGEN_HALFLINE_EN to build the mid-line strobe on halfclk; otherwise halfclk is tied low.
module hsyncgen_prog #(
  parameter int HW           = 7,
  parameter int DEF_LEN      = 128,
  parameter int DEF_HS_START = 101,
  parameter int DEF_HS_END   = 111,
  parameter int DEF_DE_START = 0,
  parameter int DEF_DE_END   = 80
) (
  input  logic          m2clock,
  input  logic          res,
  input  logic          cken,
  input  logic [HW-1:0] line_len,
  input  logic [HW-1:0] hs_start,
  input  logic [HW-1:0] hs_end,
  input  logic [HW-1:0] de_start,
  input  logic [HW-1:0] de_end,
  output logic [HW-1:0] hsc,
  output logic          iihsync,
  output logic          hde,
  output logic          vertclk,
  output logic          halfclk
);

  localparam logic [HW-1:0] DEF_LEN_C      = HW'(DEF_LEN);
  localparam logic [HW-1:0] DEF_HS_START_C = HW'(DEF_HS_START);
  localparam logic [HW-1:0] DEF_HS_END_C   = HW'(DEF_HS_END);
  localparam logic [HW-1:0] DEF_DE_START_C = HW'(DEF_DE_START);
  localparam logic [HW-1:0] DEF_DE_END_C   = HW'(DEF_DE_END);

  logic [HW-1:0] hsc_q, hsc_d;
  logic [HW-1:0] len_q, len_d;
  logic [HW-1:0] hs_start_q, hs_start_d;
  logic [HW-1:0] hs_end_q, hs_end_d;
  logic [HW-1:0] de_start_q, de_start_d;
  logic [HW-1:0] de_end_q, de_end_d;
  logic          iihsync_q, iihsync_d;
  logic          hde_q, hde_d;
  logic          vertclk_q, vertclk_d;

  logic [HW:0]   len_ext;
  logic          terminal;
  logic          hs_start_hit, hs_end_hit, de_start_hit, de_end_hit;

  // A programmed length of 0 stands for a full 2^HW-count line.
  assign len_ext  = (len_q == '0) ? {1'b1, {HW{1'b0}}} : {1'b0, len_q};
  assign terminal = (hsc_q == len_q - HW'(1));

  assign hs_start_hit = (hsc_q == hs_start_q) && ({1'b0, hs_start_q} < len_ext);
  assign hs_end_hit   = (hsc_q == hs_end_q)   && ({1'b0, hs_end_q}   < len_ext);
  assign de_start_hit = (hsc_q == de_start_q) && ({1'b0, de_start_q} < len_ext);
  assign de_end_hit   = (hsc_q == de_end_q)   && ({1'b0, de_end_q}   < len_ext);

  always_comb begin
    hsc_d      = hsc_q;
    len_d      = len_q;
    hs_start_d = hs_start_q;
    hs_end_d   = hs_end_q;
    de_start_d = de_start_q;
    de_end_d   = de_end_q;
    iihsync_d  = iihsync_q;
    hde_d      = hde_q;
    vertclk_d  = vertclk_q;
    if (cken) begin
      vertclk_d = terminal;
      if (terminal) begin
        hsc_d      = '0;
        len_d      = line_len;
        hs_start_d = hs_start;
        hs_end_d   = hs_end;
        de_start_d = de_start;
        de_end_d   = de_end;
      end else begin
        hsc_d = hsc_q + HW'(1);
      end
      // Sync favours the assert (low) edge on a tie, display enable favours its assert (high) edge.
      if (hs_start_hit)    iihsync_d = 1'b0;
      else if (hs_end_hit) iihsync_d = 1'b1;
      if (de_start_hit)    hde_d = 1'b1;
      else if (de_end_hit) hde_d = 1'b0;
    end
  end

  always_ff @(posedge m2clock or posedge res) begin
    if (res) begin
      hsc_q      <= '0;
      len_q      <= DEF_LEN_C;
      hs_start_q <= DEF_HS_START_C;
      hs_end_q   <= DEF_HS_END_C;
      de_start_q <= DEF_DE_START_C;
      de_end_q   <= DEF_DE_END_C;
      iihsync_q  <= 1'b1;
      hde_q      <= 1'b0;
      vertclk_q  <= 1'b0;
    end else begin
      hsc_q      <= hsc_d;
      len_q      <= len_d;
      hs_start_q <= hs_start_d;
      hs_end_q   <= hs_end_d;
      de_start_q <= de_start_d;
      de_end_q   <= de_end_d;
      iihsync_q  <= iihsync_d;
      hde_q      <= hde_d;
      vertclk_q  <= vertclk_d;
    end
  end

  assign hsc     = hsc_q;
  assign iihsync = iihsync_q;
  assign hde     = hde_q;
  assign vertclk = vertclk_q;

`ifdef HSYNCGEN_HALFLINE_EN
  logic          halfclk_q, halfclk_d;
  logic [HW-1:0] half_d;

  // Half point is taken from the length in force on the line being entered.
  assign half_d = (len_d == '0) ? {1'b1, {(HW-1){1'b0}}} : (len_d >> 1);

  always_comb begin
    halfclk_d = halfclk_q;
    if (cken) halfclk_d = (hsc_d == half_d);
  end

  always_ff @(posedge m2clock or posedge res) begin
    if (res) halfclk_q <= 1'b0;
    else     halfclk_q <= halfclk_d;
  end

  assign halfclk = halfclk_q;
`else
  assign halfclk = 1'b0;
`endif

endmodule

// File: tb/tb_hsyncgen_prog.sv
// tb_hsyncgen_prog: directed table, hand-written corner sequences and random stimulus
// checked cycle by cycle against a line-level reference model.
module tb_hsyncgen_prog;

  localparam int HW    = 7;
  localparam int L_MAX = 1 << HW;
`ifdef HSYNCGEN_HALFLINE_EN
  localparam bit HALF_EN = 1'b1;
`else
  localparam bit HALF_EN = 1'b0;
`endif

  logic          m2clock = 1'b0;
  logic          res = 1'b1;
  logic          cken = 1'b1;
  logic [HW-1:0] line_len, hs_start, hs_end, de_start, de_end;
  logic [HW-1:0] hsc;
  logic          iihsync, hde, vertclk, halfclk;

  int errors = 0;
  int checks = 0;

  hsyncgen_prog dut (
    .m2clock (m2clock),
    .res     (res),
    .cken    (cken),
    .line_len(line_len),
    .hs_start(hs_start),
    .hs_end  (hs_end),
    .de_start(de_start),
    .de_end  (de_end),
    .hsc     (hsc),
    .iihsync (iihsync),
    .hde     (hde),
    .vertclk (vertclk),
    .halfclk (halfclk)
  );

  always #5 m2clock = ~m2clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: counts, line length and edge positions as plain integers.
  int m_cnt, m_len, m_hs_s, m_hs_e, m_de_s, m_de_e;
  bit m_hs, m_de, m_vc, m_hc;

  task automatic model_reset();
    m_cnt = 0; m_len = 128;
    m_hs_s = 101; m_hs_e = 111; m_de_s = 0; m_de_e = 80;
    m_hs = 1'b1; m_de = 1'b0; m_vc = 1'b0; m_hc = 1'b0;
  endtask

  task automatic model_step();
    bit term;
    if (res) begin
      model_reset();
      return;
    end
    if (!cken) return;
    term = (m_cnt == m_len - 1);
    if (m_cnt == m_hs_s)      m_hs = 1'b0;
    else if (m_cnt == m_hs_e) m_hs = 1'b1;
    if (m_cnt == m_de_s)      m_de = 1'b1;
    else if (m_cnt == m_de_e) m_de = 1'b0;
    m_vc = term;
    if (term) begin
      m_cnt  = 0;
      m_len  = (line_len == 0) ? L_MAX : int'(line_len);
      m_hs_s = int'(hs_start); m_hs_e = int'(hs_end);
      m_de_s = int'(de_start); m_de_e = int'(de_end);
    end else begin
      m_cnt = m_cnt + 1;
    end
    m_hc = HALF_EN && (m_cnt == m_len / 2);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    checks++;
    if (hsc !== HW'(m_cnt) || iihsync !== m_hs || hde !== m_de ||
        vertclk !== m_vc || halfclk !== m_hc) begin
      errors++;
      $display("FAIL model t=%0t: got hsc=%0d hs=%b de=%b vc=%b hc=%b expected hsc=%0d hs=%b de=%b vc=%b hc=%b",
               $time, hsc, iihsync, hde, vertclk, halfclk, m_cnt, m_hs, m_de, m_vc, m_hc);
    end
  endtask

  task automatic check_rst(input string name);
    check({name, " hsc"}, 32'(hsc), 0);
    check({name, " iihsync"}, 32'(iihsync), 1);
    check({name, " hde"}, 32'(hde), 0);
    check({name, " vertclk"}, 32'(vertclk), 0);
    check({name, " halfclk"}, 32'(halfclk), 0);
  endtask

  task automatic cyc();
    @(posedge m2clock);
    model_step();
    @(negedge m2clock);
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_until_vclk(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!vertclk && n < limit);
  endtask

  task automatic set_defaults();
    line_len = '0; hs_start = 7'd101; hs_end = 7'd111;
    de_start = 7'd0; de_end = 7'd80; cken = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge m2clock);
    res = 1'b1;
    #1;
    check_rst("reset");
    cyc();
    res = 1'b0;
  endtask

  function automatic logic [HW-1:0] pick_len();
    if ($urandom_range(3) == 0) return HW'($urandom_range(3));
    return HW'($urandom_range(L_MAX - 1));
  endfunction

  typedef struct {
    int n;
    int exp_hsc;
    bit exp_hs;
    bit exp_de;
    bit exp_vc;
    bit exp_hc;
  } vec_t;

  vec_t tbl[14];
  int   elapsed;
  int   n;
  int   vc_cnt;
  bit   exp;

  initial begin
    tbl[0]  = '{0,   0,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1,   1,   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{64,  64,  1'b1, 1'b1, 1'b0, HALF_EN};
    tbl[3]  = '{65,  65,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{80,  80,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{81,  81,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{101, 101, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{102, 102, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{111, 111, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{112, 112, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{127, 127, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{128, 0,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{129, 1,   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{192, 64,  1'b1, 1'b1, 1'b0, HALF_EN};

    set_defaults();
    model_reset();

    // Default timing after reset release.
    do_reset();
    elapsed = 0;
    foreach (tbl[k]) begin
      while (elapsed < tbl[k].n) begin
        cyc();
        elapsed++;
      end
      check("tbl hsc", 32'(hsc), 32'(tbl[k].exp_hsc));
      check("tbl iihsync", 32'(iihsync), 32'(tbl[k].exp_hs));
      check("tbl hde", 32'(hde), 32'(tbl[k].exp_de));
      check("tbl vertclk", 32'(vertclk), 32'(tbl[k].exp_vc));
      check("tbl halfclk", 32'(halfclk), 32'(tbl[k].exp_hc));
      $display("vec %0d: n=%0d hsc=%0d hs=%b de=%b vc=%b hc=%b", k, tbl[k].n, hsc, iihsync, hde, vertclk, halfclk);
    end

    // Length change mid-line takes effect only from the next line.
    set_defaults();
    do_reset();
    run(40);
    line_len = 7'd100;
    run_until_vclk(200, n);
    check("len change current line", 32'(n), 88);
    run_until_vclk(200, n);
    check("len 100 period", 32'(n), 100);
    run(50);
    check("len 100 half hsc", 32'(hsc), 50);
    check("len 100 halfclk", 32'(halfclk), 32'(HALF_EN));
    run_until_vclk(200, n);
    check("len 100 second half", 32'(n), 50);
    $display("seq len_change: done");

    // Equal start/end: sync goes low and stays low.
    set_defaults();
    do_reset();
    hs_start = 7'd50; hs_end = 7'd50;
    run(128 + 51);
    check("eq hsync at 51", 32'(iihsync), 0);
    run(250);
    check("eq hsync later", 32'(iihsync), 0);
    $display("seq equal_edges: hsc=%0d iihsync=%b", hsc, iihsync);

    // Sync pulse spanning the wrap.
    set_defaults();
    do_reset();
    line_len = 7'd100; hs_start = 7'd90; hs_end = 7'd10;
    run(128);
    for (int i = 0; i < 120; i++) begin
      exp = (i < 100) ? (i % 100 < 91) : (i % 100 > 10);
      check("wrap hsc", 32'(hsc), 32'(i % 100));
      check("wrap iihsync", 32'(iihsync), 32'(exp));
      cyc();
    end
    $display("seq wrap_pulse: done");

    // Alternating count enable stretches strobes to two clocks.
    set_defaults();
    do_reset();
    vc_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      cken = (i % 2 == 0);
      cyc();
      if (vertclk) vc_cnt++;
    end
    cken = 1'b1;
    check("cken vertclk samples", 32'(vc_cnt), 4);
    check("cken final hsc", 32'(hsc), 0);
    $display("seq cken_toggle: vertclk samples=%0d", vc_cnt);

    // Reset mid-line while sync is low.
    set_defaults();
    do_reset();
    hs_start = 7'd50; hs_end = 7'd120;
    run(128 + 70);
    check("midreset pre hsc", 32'(hsc), 70);
    check("midreset pre iihsync", 32'(iihsync), 0);
    res = 1'b1;
    #1;
    check_rst("midreset");
    cyc();
    res = 1'b0;
    run_until_vclk(300, n);
    check("midreset full line", 32'(n), 128);
    $display("seq mid_reset: first line length=%0d", n);

    // Random programming, enables and occasional resets against the model.
    set_defaults();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(4))
          0: line_len = pick_len();
          1: hs_start = HW'($urandom_range(L_MAX - 1));
          2: hs_end   = HW'($urandom_range(L_MAX - 1));
          3: de_start = HW'($urandom_range(L_MAX - 1));
          default: de_end = HW'($urandom_range(L_MAX - 1));
        endcase
      end
      cken = ($urandom_range(3) != 0);
      if ($urandom_range(499) == 0) begin
        res = 1'b1;
        #1;
        check_rst("rand reset");
      end
      cyc();
      res = 1'b0;
    end
    $display("seq random: done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
